// File: rtl/layer_drain_streamer.sv
// layer_drain_streamer: walks a wrap-around range of register-file entries
// through the file's combinational read port and serialises each 32-bit
// entry MSB-first as four bytes on a valid/ready byte stream, carrying the
// entry's pos tag as sideband.
module layer_drain_streamer #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int POS_W  = 4
) (
   input  logic              clk_i,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W:0]   count_i,
   output logic [ADDR_W-1:0] op_address_o,
   input  logic [DATA_W-1:0] reg_i,
   input  logic [POS_W-1:0]  pos_i,
   output logic [7:0]        byte_o,
   output logic              byte_valid_o,
   input  logic              byte_ready_i,
   output logic              first_o,
   output logic              last_o,
   output logic [POS_W-1:0]  tag_o,
   output logic              busy_o,
   output logic              done_o
);

   // Largest legal drain length: every entry of the file exactly once.
   localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_COUNT = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [ADDR_W:0]     remaining_reg, remaining_next;
   logic [DATA_W-1:0]   word_reg, word_next;
   logic [POS_W-1:0]    tag_reg, tag_next;
   logic [1:0]          idx_reg, idx_next;

   logic [ADDR_W:0]     count_clamped;
   logic [1:0]          lane;
   logic                in_send;
   logic                accept;

   assign count_clamped = (count_i > MAX_COUNT) ? MAX_COUNT : count_i;
   assign in_send       = (state_reg == SEND);
   assign accept        = in_send && byte_ready_i;
   // Byte 0 is the most significant byte of the word.
   assign lane          = 2'd3 - idx_reg;

   assign op_address_o  = addr_reg;
   assign tag_o         = tag_reg;
   assign byte_valid_o  = in_send;
   assign byte_o        = in_send ? word_reg[{lane, 3'b000} +: 8] : 8'd0;
   assign first_o       = in_send && (idx_reg == 2'd0);
   assign last_o        = in_send && (idx_reg == 2'd3) && (remaining_reg == ONE_COUNT);
   assign busy_o        = (state_reg != IDLE);
   assign done_o        = (state_reg == DONE);

   // State and datapath registers; reset aborts any drain in progress.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         remaining_reg <= '0;
         word_reg      <= '0;
         tag_reg       <= '0;
         idx_reg       <= '0;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         remaining_reg <= remaining_next;
         word_reg      <= word_next;
         tag_reg       <= tag_next;
         idx_reg       <= idx_next;
      end
   end

   // Next-state and datapath update for the drain sequence.
   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      remaining_next = remaining_reg;
      word_next      = word_reg;
      tag_next       = tag_reg;
      idx_next       = idx_reg;
      case (state_reg)
         IDLE: begin
            if (start_i) begin
               addr_next      = base_addr_i;
               remaining_next = count_clamped;
               state_next     = (count_clamped == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            // Whatever the file shows at this edge is the captured entry.
            word_next  = reg_i;
            tag_next   = pos_i;
            idx_next   = 2'd0;
            state_next = SEND;
         end
         SEND: begin
            if (accept) begin
               idx_next = idx_reg + 2'd1;
               if (idx_reg == 2'd3) begin
                  remaining_next = remaining_reg - ONE_COUNT;
                  if (remaining_reg == ONE_COUNT) begin
                     state_next = DONE;
                  end else begin
                     // Address wraps naturally at the file depth.
                     addr_next  = addr_reg + ADDR_W'(1);
                     state_next = FETCH;
                  end
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_layer_drain_streamer.sv
// Testbench for layer_drain_streamer: a behavioural register file feeds the
// read port, and every accepted byte is compared against a queue built from
// the drain rules (entry order, MSB-first bytes, first/last/tag sideband).
module tb_layer_drain_streamer;

   logic        clk_i = 1'b0;
   logic        reset_n;
   logic        start_i;
   logic [4:0]  base_addr_i;
   logic [5:0]  count_i;
   logic [4:0]  op_address_o;
   logic [31:0] reg_i;
   logic [3:0]  pos_i;
   logic [7:0]  byte_o;
   logic        byte_valid_o;
   logic        byte_ready_i;
   logic        first_o;
   logic        last_o;
   logic [3:0]  tag_o;
   logic        busy_o;
   logic        done_o;

   logic [31:0] mem     [32];
   logic [3:0]  pos_mem [32];

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   assign reg_i = mem[op_address_o];
   assign pos_i = pos_mem[op_address_o];

   layer_drain_streamer #(.ADDR_W(5), .DATA_W(32), .POS_W(4)) dut (
      .clk_i        (clk_i),
      .reset_n      (reset_n),
      .start_i      (start_i),
      .base_addr_i  (base_addr_i),
      .count_i      (count_i),
      .op_address_o (op_address_o),
      .reg_i        (reg_i),
      .pos_i        (pos_i),
      .byte_o       (byte_o),
      .byte_valid_o (byte_valid_o),
      .byte_ready_i (byte_ready_i),
      .first_o      (first_o),
      .last_o       (last_o),
      .tag_o        (tag_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic randomize_mem();
      for (int i = 0; i < 32; i++) begin
         mem[i]     = $urandom;
         pos_mem[i] = 4'($urandom_range(15));
      end
   endtask

   function automatic logic [21:0] all_outputs();
      return {op_address_o, byte_o, byte_valid_o, first_o, last_o, tag_o, busy_o, done_o};
   endfunction

   // One drain transaction. poke pulses start_i mid-SEND; abort_at >= 0
   // asserts reset while that byte index is presented.
   task automatic drain(input int base, input int cnt, input int rdy_pct,
                        input bit poke, input int abort_at);
      logic [13:0] exp_q [$];
      logic [13:0] cur, prev_cur, e;
      logic [31:0] sh;
      int n, cycles, got, fetches, a;
      bit done_seen, prev_stall;

      n = (cnt > 32) ? 32 : cnt;
      for (int en = 0; en < n; en++) begin
         a = (base + en) % 32;
         for (int b = 0; b < 4; b++) begin
            sh = mem[a] >> (24 - 8 * b);
            exp_q.push_back({sh[7:0], 1'(b == 0), 1'((b == 3) && (en == n - 1)), pos_mem[a]});
         end
      end

      @(negedge clk_i);
      check_eq("idle_busy", 32'(busy_o), 0);
      check_eq("idle_done", 32'(done_o), 0);
      start_i      = 1'b1;
      base_addr_i  = base[4:0];
      count_i      = cnt[5:0];
      byte_ready_i = ($urandom_range(99) < rdy_pct);

      cycles = 0; got = 0; fetches = 0; done_seen = 0; prev_stall = 0; prev_cur = '0;
      while (!done_seen && cycles < 3000) begin
         @(negedge clk_i);
         cycles++;
         start_i = 1'b0;
         cur = {byte_o, first_o, last_o, tag_o};
         if (prev_stall) begin
            check_eq("stall_valid", 32'(byte_valid_o), 1);
            check_eq("stall_hold", 32'(cur), 32'(prev_cur));
         end
         if (busy_o && !byte_valid_o && !done_o) begin
            check_eq("fetch_addr", 32'(op_address_o), (base + fetches) % 32);
            fetches++;
         end
         if (done_o) begin
            done_seen = 1;
            check_eq("done_bytes", got, n * 4);
            check_eq("done_valid", 32'(byte_valid_o), 0);
            if (rdy_pct == 100) check_eq("done_latency", cycles, 5 * n + 1);
         end else begin
            check_eq("busy", 32'(busy_o), 1);
         end
         if (abort_at >= 0 && byte_valid_o && got == abort_at) begin
            reset_n = 1'b0;
            #1;
            check_eq("abort_outputs", 32'(all_outputs()), 0);
            byte_ready_i = 1'b0;
            repeat (3) begin
               @(negedge clk_i);
               check_eq("abort_done", 32'(done_o), 0);
               check_eq("abort_busy", 32'(busy_o), 0);
            end
            reset_n = 1'b1;
            $display("drain base=%0d count=%0d aborted after %0d bytes", base, cnt, got);
            return;
         end
         if (poke && byte_valid_o && got == 5) start_i = 1'b1;
         byte_ready_i = ($urandom_range(99) < rdy_pct);
         if (byte_valid_o && byte_ready_i) begin
            if (exp_q.size() == 0) begin
               check_eq("extra_byte", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("byte", 32'(cur), 32'(e));
            end
            got++;
         end
         prev_stall = byte_valid_o && !byte_ready_i;
         prev_cur   = cur;
      end
      if (!done_seen) check_eq("timeout", 0, 1);
      check_eq("byte_total", got, n * 4);
      $display("drain base=%0d count=%0d ready=%0d%% bytes=%0d cycles=%0d",
               base, cnt, rdy_pct, got, cycles);
   endtask

   initial begin
      reset_n      = 1'b0;
      start_i      = 1'b0;
      base_addr_i  = '0;
      count_i      = '0;
      byte_ready_i = 1'b0;
      randomize_mem();
      repeat (3) @(negedge clk_i);
      check_eq("reset_outputs", 32'(all_outputs()), 0);
      reset_n = 1'b1;

      // Single entry with a known word and tag.
      mem[3]     = 32'hA1B2C3D4;
      pos_mem[3] = 4'h5;
      drain(3, 1, 100, 1'b0, -1);

      // Wrap-around, then the same range under backpressure.
      drain(30, 4, 100, 1'b0, -1);
      drain(30, 4, 50, 1'b0, -1);

      // Zero count and clamp of an oversized count.
      drain(7, 0, 100, 1'b0, -1);
      drain(5, 40, 100, 1'b0, -1);

      // Start pulsed during SEND must be ignored.
      drain(12, 6, 60, 1'b1, -1);

      // Reset during byte 2 of entry 1, then a fresh drain.
      drain(0, 3, 100, 1'b0, 6);
      drain(9, 5, 100, 1'b0, -1);

      // Randomized drains.
      for (int t = 0; t < 8; t++) begin
         randomize_mem();
         drain(int'($urandom_range(31)), int'($urandom_range(40)),
               int'($urandom_range(100, 30)), 1'(t[0]), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
